regs_wr_arbiter: RTL and testbench
==================================

// Module: regs_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (reg_addr/reg_data/reg_en into the
//  decode/register stage) between two requesters: ALU writeback (wb_*) and load
//  return (ld_*). Each requester gets a one-entry holding slot with valid/ready;
//  slots are granted oldest-first, round-robin on ties. Also flags decode-stage
//  read hazards against writes not yet committed (stall).
// PARAMETERS
//  DATA_WIDTH      16  register data width
//  REG_ADDR_WIDTH  4   register address width
// PORTS
//  clk_in    in   1                clock, all state on rising edge
//  RST       in   1                asynchronous reset, active-low
//  wb_valid  in   1                writeback request valid
//  wb_addr   in   REG_ADDR_WIDTH   writeback destination register
//  wb_data   in   DATA_WIDTH       writeback data
//  wb_ready  out  1                writeback slot can accept this cycle
//  ld_valid  in   1                load-return request valid
//  ld_addr   in   REG_ADDR_WIDTH   load destination register
//  ld_data   in   DATA_WIDTH       load data
//  ld_ready  out  1                load slot can accept this cycle
//  rd_addr1  in   REG_ADDR_WIDTH   decode read address 1
//  rd_addr2  in   REG_ADDR_WIDTH   decode read address 2
//  reg_addr  out  REG_ADDR_WIDTH   write-port address (registered)
//  reg_data  out  DATA_WIDTH       write-port data (registered)
//  reg_en    out  1                write-port enable, one cycle per write (registered)
//  stall     out  1                read address hits an uncommitted write
// BEHAVIOUR
//  Reset (RST=0, async): both slots empty, age bits clear, rr pointer = wb,
//   reg_en=0, reg_addr=0, reg_data=0. wb_ready=ld_ready=0 and stall=0 while RST=0.
//  State: per slot {full, addr, data, old}; rr pointer; output regs.
//  Transfer: x accepted at a rising edge when x_valid & x_ready; slot loads addr/data.
//  Grant (combinational, from registered slot state only):
//   - one full slot -> that slot granted.
//   - both full, one old -> old slot granted.
//   - both full, same age -> if addrs equal, wb granted (ld value persists);
//     else the rr pointer slot is granted, then pointer flips to the other.
//  Per edge: granted slot -> reg_addr/reg_data, reg_en=1, slot clears (unless
//   refilled same edge). No grant -> reg_en=0, reg_addr/reg_data hold.
//  old bit: set on a full, ungranted slot when the other slot loads; cleared
//   when the slot is granted or emptied.
//  x_ready = RST & (!x_full | grant_x): back-to-back accepts per requester, one
//   write per cycle total. Ungranted full slot -> x_ready=0 (backpressure).
//  Latency: accept at edge k -> reg_en=1 from edge k+1 if uncontested; max k+2.
//  Simultaneous accept + grant on same slot: new entry loads, old one written.
//  stall = any full slot addr == rd_addr1 or rd_addr2, or (reg_en & reg_addr ==
//   rd_addr1/2). Combinational; no address is exempt.
//  Reset mid-operation: pending slot contents are discarded, not written.
// TESTING
//  wb_valid 1 cycle, addr=3 data=0x1234 -> next cycle reg_en=1 addr=3 data=0x1234; then reg_en=0.
//  wb(addr 1,0xAAAA) and ld(addr 2,0x5555) same edge, rr=wb -> addr1 then addr2 consecutive; rr ends on wb.
//  Same edge wb(addr 5,0x0001), ld(addr 5,0x0002) -> writes 0x0001 then 0x0002.
//  ld held in slot, wb streams 4 beats -> ld (old) written 2nd; wb_ready drops 1 cycle, no loss.
//  ld slot addr=7 pending, rd_addr1=7 -> stall=1 until the cycle after its reg_en cycle.
//  RST low with both slots full -> reg_en=0, readies=0, stall=0; no writes after release.

Source files
------------

// File: rtl/regs_wr_arbiter.sv
// Arbitrates ALU writeback and load return onto one register-file write port.
// Each requester has a one-entry slot; the older slot wins, and ties go round-robin.
module regs_wr_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_ready,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr2,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_data,
  output logic                      reg_en,
  output logic                      stall
);

  logic                      r_wb_full;
  logic                      r_wb_old;
  logic [REG_ADDR_WIDTH-1:0] r_wb_addr;
  logic [DATA_WIDTH-1:0]     r_wb_data;
  logic                      r_ld_full;
  logic                      r_ld_old;
  logic [REG_ADDR_WIDTH-1:0] r_ld_addr;
  logic [DATA_WIDTH-1:0]     r_ld_data;
  logic                      r_rr;  // 0 = wb next on a tie, 1 = ld next
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0]     r_reg_data;
  logic                      r_reg_en;

  logic w_grant_wb;
  logic w_grant_ld;
  logic w_addr_eq;
  logic w_same_age;
  logic w_wb_load;
  logic w_ld_load;
  logic w_wb_hit;
  logic w_ld_hit;
  logic w_out_hit;

  assign w_addr_eq  = (r_wb_addr == r_ld_addr);
  assign w_same_age = (r_wb_old == r_ld_old);

  // Equal addresses on a tie: wb first so the load value is the one left in the file.
  always_comb begin
    w_grant_wb = 1'b0;
    w_grant_ld = 1'b0;
    if (r_wb_full && !r_ld_full) begin
      w_grant_wb = 1'b1;
    end else if (!r_wb_full && r_ld_full) begin
      w_grant_ld = 1'b1;
    end else if (r_wb_full && r_ld_full) begin
      if (!w_same_age) begin
        w_grant_wb = r_wb_old;
        w_grant_ld = r_ld_old;
      end else if (w_addr_eq || !r_rr) begin
        w_grant_wb = 1'b1;
      end else begin
        w_grant_ld = 1'b1;
      end
    end
  end

  assign wb_ready  = RST & (!r_wb_full | w_grant_wb);
  assign ld_ready  = RST & (!r_ld_full | w_grant_ld);
  assign w_wb_load = wb_valid & wb_ready;
  assign w_ld_load = ld_valid & ld_ready;

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_wb_full <= 1'b0;
      r_wb_old  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_wb_load) begin
      r_wb_full <= 1'b1;
      r_wb_old  <= 1'b0;
      r_wb_addr <= wb_addr;
      r_wb_data <= wb_data;
    end else if (w_grant_wb) begin
      r_wb_full <= 1'b0;
      r_wb_old  <= 1'b0;
    end else if (r_wb_full && w_ld_load) begin
      r_wb_old  <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_ld_full <= 1'b0;
      r_ld_old  <= 1'b0;
      r_ld_addr <= '0;
      r_ld_data <= '0;
    end else if (w_ld_load) begin
      r_ld_full <= 1'b1;
      r_ld_old  <= 1'b0;
      r_ld_addr <= ld_addr;
      r_ld_data <= ld_data;
    end else if (w_grant_ld) begin
      r_ld_full <= 1'b0;
      r_ld_old  <= 1'b0;
    end else if (r_ld_full && w_wb_load) begin
      r_ld_old  <= 1'b1;
    end
  end

  // Pointer always moves to the requester that was not just served.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_rr       <= 1'b0;
      r_reg_en   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
    end else begin
      r_reg_en <= w_grant_wb | w_grant_ld;
      if (w_grant_wb) begin
        r_rr       <= 1'b1;
        r_reg_addr <= r_wb_addr;
        r_reg_data <= r_wb_data;
      end else if (w_grant_ld) begin
        r_rr       <= 1'b0;
        r_reg_addr <= r_ld_addr;
        r_reg_data <= r_ld_data;
      end
    end
  end

  assign w_wb_hit  = r_wb_full & ((r_wb_addr == rd_addr1) | (r_wb_addr == rd_addr2));
  assign w_ld_hit  = r_ld_full & ((r_ld_addr == rd_addr1) | (r_ld_addr == rd_addr2));
  assign w_out_hit = r_reg_en & ((r_reg_addr == rd_addr1) | (r_reg_addr == rd_addr2));
  assign stall     = RST & (w_wb_hit | w_ld_hit | w_out_hit);

  assign reg_addr = r_reg_addr;
  assign reg_data = r_reg_data;
  assign reg_en   = r_reg_en;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter: ordering, backpressure, hazard stall and reset.
module tb_regs_wr_arbiter;
  logic        clk_in = 1'b0;
  logic        RST;
  logic        wb_valid, ld_valid, wb_ready, ld_ready;
  logic [3:0]  wb_addr, ld_addr, rd_addr1, rd_addr2, reg_addr;
  logic [15:0] wb_data, ld_data, reg_data;
  logic        reg_en, stall;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  log_addr [0:31];
  logic [15:0] log_data [0:31];
  int          log_cnt = 0;

  regs_wr_arbiter #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut (
    .clk_in(clk_in), .RST(RST),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_en(reg_en), .stall(stall)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (RST && reg_en && log_cnt < 32) begin
      log_addr[log_cnt] = reg_addr;
      log_data[log_cnt] = reg_data;
      log_cnt = log_cnt + 1;
    end
  end

  task automatic cyc();
    @(negedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; wb_valid = 0; ld_valid = 0; wb_addr = 0; ld_addr = 0;
    wb_data = 0; ld_data = 0; rd_addr1 = 0; rd_addr2 = 0;
    cyc(); cyc();
    n_chk++; if (reg_en !== 1'b0 || reg_addr !== 4'd0 || reg_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_outputs: en=%b addr=%0d data=%h, want 0/0/0", reg_en, reg_addr, reg_data); end
    n_chk++; if (wb_ready !== 1'b0 || ld_ready !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: wb_rdy=%b ld_rdy=%b stall=%b, want 0/0/0", wb_ready, ld_ready, stall); end
    RST = 1'b1;
    cyc();
    n_chk++; if (wb_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: wb=%b ld=%b, want 1/1", wb_ready, ld_ready); end
  endtask

  // Simultaneous wb/ld on distinct addresses; expects the given one first.
  task automatic tie_pair(input string nm, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [3:0] la, input logic [15:0] ld, input logic wb_first);
    wb_valid = 1; wb_addr = wa; wb_data = wd;
    ld_valid = 1; ld_addr = la; ld_data = ld;
    cyc();
    wb_valid = 0; ld_valid = 0; #1;
    n_chk++; if (reg_en !== 1'b0 || (wb_first && (wb_ready !== 1'b1 || ld_ready !== 1'b0))) begin
      n_fail++; $display("FAIL %s_accept: en=%b wb_rdy=%b ld_rdy=%b", nm, reg_en, wb_ready, ld_ready); end
    cyc();
    n_chk++; if (reg_en !== 1'b1 || reg_addr !== (wb_first ? wa : la) || reg_data !== (wb_first ? wd : ld)) begin
      n_fail++; $display("FAIL %s_first: en=%b addr=%0d data=%h, want 1/%0d/%h", nm, reg_en, reg_addr, reg_data,
                         wb_first ? wa : la, wb_first ? wd : ld); end
    cyc();
    n_chk++; if (reg_en !== 1'b1 || reg_addr !== (wb_first ? la : wa) || reg_data !== (wb_first ? ld : wd)) begin
      n_fail++; $display("FAIL %s_second: en=%b addr=%0d data=%h, want 1/%0d/%h", nm, reg_en, reg_addr, reg_data,
                         wb_first ? la : wa, wb_first ? ld : wd); end
    cyc();
    n_chk++; if (reg_en !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle: en=%b, want 0", nm, reg_en); end
  endtask

  task automatic test_tie();
    tie_pair("tie", 4'd1, 16'hAAAA, 4'd2, 16'h5555, 1'b1);
    // Pointer must be back on wb after the pair completes.
    tie_pair("tie_again", 4'd8, 16'h0808, 4'd9, 16'h0909, 1'b1);
  endtask

  task automatic test_single();
    wb_valid = 1; wb_addr = 4'd3; wb_data = 16'h1234;
    cyc();
    wb_valid = 0;
    cyc();
    n_chk++; if (reg_en !== 1'b1 || reg_addr !== 4'd3 || reg_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_write: en=%b addr=%0d data=%h, want 1/3/1234", reg_en, reg_addr, reg_data); end
    cyc();
    n_chk++; if (reg_en !== 1'b0 || reg_addr !== 4'd3 || reg_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_hold: en=%b addr=%0d data=%h, want 0/3/1234", reg_en, reg_addr, reg_data); end
  endtask

  task automatic test_same_addr();
    wb_valid = 1; wb_addr = 4'd5; wb_data = 16'h0001;
    ld_valid = 1; ld_addr = 4'd5; ld_data = 16'h0002;
    cyc();
    wb_valid = 0; ld_valid = 0;
    cyc();
    n_chk++; if (reg_en !== 1'b1 || reg_addr !== 4'd5 || reg_data !== 16'h0001) begin
      n_fail++; $display("FAIL same_addr_first: en=%b addr=%0d data=%h, want 1/5/0001", reg_en, reg_addr, reg_data); end
    cyc();
    n_chk++; if (reg_en !== 1'b1 || reg_addr !== 4'd5 || reg_data !== 16'h0002) begin
      n_fail++; $display("FAIL same_addr_second: en=%b addr=%0d data=%h, want 1/5/0002", reg_en, reg_addr, reg_data); end
    cyc();
  endtask

  task automatic test_back_to_back();
    int beat = 0;
    int bp_cycles = 0;
    logic acc_wb, acc_ld;
    log_cnt = 0;
    ld_valid = 1; ld_addr = 4'd14; ld_data = 16'hC0DE;
    for (int i = 0; i < 20 && (beat < 4 || ld_valid); i++) begin
      wb_valid = (beat < 4);
      wb_addr  = 4'(10 + beat);
      wb_data  = 16'hB000 + 16'(beat);
      #1;
      acc_wb = wb_valid & wb_ready;
      acc_ld = ld_valid & ld_ready;
      if (wb_valid && !wb_ready) bp_cycles++;
      cyc();
      if (acc_wb) beat++;
      if (acc_ld) ld_valid = 0;
    end
    wb_valid = 0; ld_valid = 0;
    n_chk++; if (beat !== 4) begin
      n_fail++; $display("FAIL b2b_timeout: beats accepted=%0d, want 4", beat); end
    n_chk++; if (bp_cycles !== 1) begin
      n_fail++; $display("FAIL b2b_backpressure: wb_ready low cycles=%0d, want 1", bp_cycles); end
    repeat (4) cyc();
    n_chk++; if (log_cnt !== 5) begin
      n_fail++; $display("FAIL b2b_count: writes=%0d, want 5", log_cnt); end
    n_chk++; if (log_addr[1] !== 4'd14 || log_data[1] !== 16'hC0DE) begin
      n_fail++; $display("FAIL b2b_ld_second: addr=%0d data=%h, want 14/c0de", log_addr[1], log_data[1]); end
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (k == 0) ? 0 : k + 1;
      n_chk++; if (log_addr[idx] !== 4'(10 + k) || log_data[idx] !== 16'hB000 + 16'(k)) begin
        n_fail++; $display("FAIL b2b_wb_beat%0d: addr=%0d data=%h, want %0d/%h", k, log_addr[idx], log_data[idx],
                           10 + k, 16'hB000 + 16'(k)); end
    end
  endtask

  task automatic test_stall();
    rd_addr1 = 4'd7; rd_addr2 = 4'd0;
    ld_valid = 1; ld_addr = 4'd7; ld_data = 16'h7777;
    #1;
    n_chk++; if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_before: stall=%b, want 0", stall); end
    cyc();
    ld_valid = 0; #1;
    n_chk++; if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_slot_rd1: stall=%b, want 1", stall); end
    rd_addr1 = 4'd0; rd_addr2 = 4'd7; #1;
    n_chk++; if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_slot_rd2: stall=%b, want 1", stall); end
    rd_addr1 = 4'd7; rd_addr2 = 4'd0;
    cyc();
    n_chk++; if (stall !== 1'b1 || reg_en !== 1'b1 || reg_addr !== 4'd7) begin
      n_fail++; $display("FAIL stall_write_cycle: stall=%b en=%b addr=%0d, want 1/1/7", stall, reg_en, reg_addr); end
    cyc();
    n_chk++; if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_cleared: stall=%b, want 0", stall); end
  endtask

  task automatic test_reset_midway();
    rd_addr1 = 4'd6; rd_addr2 = 4'd4;
    wb_valid = 1; wb_addr = 4'd4; wb_data = 16'h4444;
    ld_valid = 1; ld_addr = 4'd6; ld_data = 16'h6666;
    cyc();
    cyc();
    n_chk++; if (reg_en !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: en=%b stall=%b, want 1/1", reg_en, stall); end
    RST = 1'b0; #1;
    n_chk++; if (reg_en !== 1'b0 || reg_addr !== 4'd0 || reg_data !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: en=%b addr=%0d data=%h, want 0/0/0", reg_en, reg_addr, reg_data); end
    n_chk++; if (wb_ready !== 1'b0 || ld_ready !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: wb_rdy=%b ld_rdy=%b stall=%b, want 0/0/0", wb_ready, ld_ready, stall); end
    repeat (2) cyc();
    wb_valid = 0; ld_valid = 0;
    log_cnt = 0;
    cyc();
    RST = 1'b1;
    repeat (5) cyc();
    n_chk++; if (log_cnt !== 0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_writes: writes=%0d stall=%b, want 0/0", log_cnt, stall); end
    n_chk++; if (wb_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_post_ready: wb=%b ld=%b, want 1/1", wb_ready, ld_ready); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_same_addr();
    test_back_to_back();
    test_stall();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
